collector_drain_arbiter: RTL

//  Round-robin drain scheduler between NUM_SRC collector receive FIFOs and one downstream consumer (MVM tile input).

---
 rtl/collector_drain_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/collector_drain_arbiter.sv
// Round-robin drain scheduler: grants one collector FIFO at a time, pops BURST words from it and
// forwards them through a registered valid/ready stage. Define DRAIN_ARB_PERF_EN for perf counters.
module collector_drain_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATAW   = 512,
  parameter int BURST   = 8,
  localparam int SRCW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_rdy,
  input  logic [NUM_SRC*DATAW-1:0]   src_rdata,
  output logic [NUM_SRC-1:0]         src_ren,
  output logic                       out_valid,
  output logic [DATAW-1:0]           out_data,
  output logic [SRCW-1:0]            out_src,
  output logic                       out_last,
  input  logic                       out_ready
`ifdef DRAIN_ARB_PERF_EN
  ,
  output logic [31:0]                perf_words,
  output logic [31:0]                perf_stall
`endif
);

  localparam int CNTW = $clog2(BURST + 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [SRCW-1:0]  gnt_reg, gnt_next;
  logic [SRCW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [CNTW-1:0]  beat_cnt_reg, beat_cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic [DATAW-1:0] out_data_reg, out_data_next;
  logic [SRCW-1:0]  out_src_reg, out_src_next;
  logic             out_last_reg, out_last_next;

  logic [DATAW-1:0]   src_word [NUM_SRC];
  logic [SRCW-1:0]    cand_idx [NUM_SRC];
  logic [NUM_SRC-1:0] cand_rdy;
  logic               scan_hit;
  logic [SRCW-1:0]    scan_gnt;
  logic               gnt_rdy;
  logic               pop;
  logic               last_beat;
  logic [SRCW-1:0]    ptr_after_gnt;

  // Candidate k is the source k places after rr_ptr, wrapping at NUM_SRC.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [SRCW:0] cand_sum;
      assign src_word[gi] = src_rdata[gi*DATAW +: DATAW];
      assign cand_sum     = {1'b0, rr_ptr_reg} + (SRCW+1)'(gi);
      assign cand_idx[gi] = (cand_sum >= (SRCW+1)'(NUM_SRC)) ?
                            SRCW'(cand_sum - (SRCW+1)'(NUM_SRC)) : SRCW'(cand_sum);
      assign cand_rdy[gi] = src_rdy[cand_idx[gi]];
      assign src_ren[gi]  = pop && (gnt_reg == SRCW'(gi));
    end
  endgenerate

  always_comb begin
    scan_hit = |cand_rdy;
    scan_gnt = cand_idx[0];
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (cand_rdy[k]) scan_gnt = cand_idx[k];
    end
  end

  // Pops are suppressed during reset so no word leaves a FIFO only to be discarded.
  assign gnt_rdy       = src_rdy[gnt_reg];
  assign pop           = !rst && (state_reg == ST_BURST) && gnt_rdy && (!out_valid_reg || out_ready);
  assign last_beat     = (beat_cnt_reg == CNTW'(BURST - 1));
  assign ptr_after_gnt = (gnt_reg == SRCW'(NUM_SRC - 1)) ? '0 : gnt_reg + SRCW'(1);

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    rr_ptr_next    = rr_ptr_reg;
    beat_cnt_next  = beat_cnt_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_src_next   = out_src_reg;
    out_last_next  = out_last_reg;

    case (state_reg)
      ST_IDLE: begin
        if (scan_hit) begin
          gnt_next   = scan_gnt;
          state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        if (pop) begin
          if (last_beat) begin
            beat_cnt_next = '0;
            rr_ptr_next   = ptr_after_gnt;
            state_next    = ST_IDLE;
          end else begin
            beat_cnt_next = beat_cnt_reg + CNTW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A pop refills the output register even when the current word is accepted this cycle.
    if (pop) begin
      out_valid_next = 1'b1;
      out_data_next  = src_word[gnt_reg];
      out_src_next   = gnt_reg;
      out_last_next  = last_beat;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      gnt_reg       <= '0;
      rr_ptr_reg    <= '0;
      beat_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      rr_ptr_reg    <= rr_ptr_next;
      beat_cnt_reg  <= beat_cnt_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_src_reg   <= out_src_next;
      out_last_reg  <= out_last_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;
  assign out_last  = out_last_reg;

`ifdef DRAIN_ARB_PERF_EN
  logic [31:0] perf_words_reg;
  logic [31:0] perf_stall_reg;
  logic        word_acc;
  logic        stall_cyc;

  // A stall is a burst cycle starved by the source or blocked by the consumer.
  assign word_acc  = out_valid_reg && out_ready;
  assign stall_cyc = (state_reg == ST_BURST) && (!gnt_rdy || (out_valid_reg && !out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_words_reg <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (word_acc && (perf_words_reg != 32'hFFFF_FFFF)) perf_words_reg <= perf_words_reg + 32'd1;
      if (stall_cyc && (perf_stall_reg != 32'hFFFF_FFFF)) perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_words = perf_words_reg;
  assign perf_stall = perf_stall_reg;
`endif

endmodule
